uart_tx_port: RTL and testbench

//  Memory-mapped serial transmitter. It is a bus responder to the drisc load/store interface,

---
 rtl/uart_tx_port.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter: bus writes fill a byte FIFO that a
// serializer drains onto tx, LSB first, with back-to-back frames when data waits.
module uart_tx_port #(
  parameter int CLOCKS_PER_BIT  = 16,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  address,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_enable,
  output logic        tx
);

  localparam int DEPTH   = 2 ** FIFO_DEPTH_LOG2;
  localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;
  localparam int BAUD_W  = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [CNT_W-1:0]           count_reg;
  logic [CNT_W-1:0]           count_next;
  logic                       ovf_reg;
  logic                       ovf_next;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [BAUD_W-1:0] baud_reg;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_idx_reg;
  logic [2:0]        bit_idx_next;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_next;
  logic              tx_reg;
  logic              tx_next;

  logic [1:0] sel;
  logic       data_wr;
  logic       status_wr;
  logic       empty;
  logic       full;
  logic       busy;
  logic       baud_done;
  logic       pop;
  logic       push_ok;
  logic [7:0] pop_byte;
  logic [7:0] count_byte;
  logic       unused_bits;

  assign sel        = address[3:2];
  assign data_wr    = write && (sel == REG_DATA);
  assign status_wr  = write && (sel == REG_STATUS);
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == COUNT_FULL);
  assign busy       = (state_reg != ST_IDLE);
  assign baud_done  = (baud_reg == BAUD_LAST);
  assign pop_byte   = fifo_mem[rd_ptr_reg];
  assign count_byte = 8'(count_reg);
  assign unused_bits = ^{data_size, data_in[31:8], address[1:0]};

  // A byte leaves the FIFO when idle, or on the last stop cycle for a seamless next frame.
  assign pop     = !empty && ((state_reg == ST_IDLE) ||
                              ((state_reg == ST_STOP) && baud_done));
  assign push_ok = data_wr && (!full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // A dropped push outranks a simultaneous clear.
  always_comb begin
    ovf_next = ovf_reg;
    if (data_wr && !push_ok) begin
      ovf_next = 1'b1;
    end else if (status_wr) begin
      ovf_next = 1'b0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    case (state_reg)
      ST_IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        if (pop) begin
          state_next = ST_START;
          shift_next = pop_byte;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_next    = '0;
          state_next   = ST_DATA;
          bit_idx_next = 3'd0;
          tx_next      = shift_reg[0];
          shift_next   = shift_reg >> 1;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (pop) begin
            state_next = ST_START;
            shift_next = pop_byte;
            tx_next    = 1'b0;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= data_in[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      ovf_reg     <= 1'b0;
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
      tx_reg      <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + FIFO_DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + FIFO_DEPTH_LOG2'(1);
      end
      count_reg   <= count_next;
      ovf_reg     <= ovf_next;
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    data_out = 32'd0;
    if (read && (sel == REG_STATUS)) begin
      data_out = {16'd0, count_byte, 4'd0, ovf_reg, busy, empty, full};
    end
  end

  assign data_out_enable = read;
  assign tx              = tx_reg;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed and random bus traffic against a queue-based model of the FIFO and
// the expected serial waveform; checks tx every cycle and read data every cycle.
module tb_uart_tx_port;

  localparam int CPB   = 4;
  localparam int DLOG  = 3;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [3:0]  address = 4'd0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        data_out_enable;
  logic        tx;

  uart_tx_port #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DLOG)) dut (
    .clock(clock),
    .reset(reset),
    .write(write),
    .read(read),
    .address(address),
    .data_size(data_size),
    .data_in(data_in),
    .data_out(data_out),
    .data_out_enable(data_out_enable),
    .tx(tx)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending bytes, sticky overflow, and the remaining tx samples of the current frame.
  byte unsigned m_q[$];
  logic         m_wave[$];
  logic         m_ovf  = 1'b0;
  logic         m_tx   = 1'b1;
  logic         m_busy = 1'b0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    logic [7:0] c;
    logic [31:0] v;
    c = 8'(m_q.size());
    v = 32'd0;
    if (addr[3:2] == 2'd1) begin
      v = {16'd0, c, 4'd0, m_ovf, m_busy, (m_q.size() == 0), (m_q.size() == DEPTH)};
    end
    return v;
  endfunction

  function automatic void model_edge(input logic rst, input logic wr,
                                     input logic [3:0] addr, input logic [31:0] din);
    logic        full_pre;
    logic        popped;
    byte unsigned b;
    logic        bitv;
    if (!rst) begin
      m_q.delete();
      m_wave.delete();
      m_ovf  = 1'b0;
      m_tx   = 1'b1;
      m_busy = 1'b0;
      return;
    end
    full_pre = (m_q.size() == DEPTH);
    popped   = 1'b0;
    if (m_wave.size() == 0) begin
      if (m_q.size() > 0) begin
        b      = m_q.pop_front();
        popped = 1'b1;
        for (int k = 0; k < 10; k++) begin
          if (k == 0)      bitv = 1'b0;
          else if (k == 9) bitv = 1'b1;
          else             bitv = b[k-1];
          for (int j = 0; j < CPB; j++) m_wave.push_back(bitv);
        end
        m_busy = 1'b1;
        $display("frame start byte=%02h", b);
      end else begin
        m_busy = 1'b0;
      end
    end
    if (m_wave.size() > 0) m_tx = m_wave.pop_front();
    else                   m_tx = 1'b1;
    if (wr && addr[3:2] == 2'd0) begin
      if (!full_pre || popped) m_q.push_back(din[7:0]);
      else                     m_ovf = 1'b1;
    end else if (wr && addr[3:2] == 2'd1) begin
      m_ovf = 1'b0;
    end
  endfunction

  task automatic cycle(input logic rst, input logic wr, input logic rd,
                       input logic [3:0] addr, input logic [31:0] din);
    reset     = rst;
    write     = wr;
    read      = rd;
    address   = addr;
    data_in   = din;
    data_size = 2'($urandom_range(0, 3));
    #1;
    check32("data_out", data_out, rd ? model_read(addr) : 32'd0);
    check32("data_out_enable", {31'd0, data_out_enable}, {31'd0, rd});
    if (wr) $display("write addr=%h data=%h", addr, din);
    @(posedge clock);
    model_edge(rst, wr, addr, din);
    #1;
    check32("tx", {31'd0, tx}, {31'd0, m_tx});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1, 4'h4, 32'd0);
  endtask

  task automatic push(input logic [7:0] b);
    cycle(1'b1, 1'b1, 1'b0, 4'h0, {24'($urandom), b});
  endtask

  initial begin
    int r;
    @(posedge clock);
    #1;
    // Reset held for two cycles, then STATUS and the read-enable behaviour.
    cycle(1'b0, 1'b0, 1'b0, 4'h4, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 4'h4, 32'd0);
    address = 4'h4;
    read    = 1'b1;
    #1;
    check32("reset_status", data_out, 32'h0000_0002);
    check32("reset_tx", {31'd0, tx}, 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 4'h4, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 4'h4, 32'd0);

    // Single frame of 0x55.
    push(8'h55);
    idle(45);

    // Burst of 10: one in flight, eight buffered, last dropped.
    for (int i = 0; i < 10; i++) push(8'($urandom));
    address = 4'h4;
    read    = 1'b1;
    write   = 1'b0;
    #1;
    check32("burst_status", data_out, 32'h0000_080D);
    idle(9 * 10 * CPB + 10);

    // Two contiguous frames.
    push(8'hA3);
    push(8'h0F);
    idle(2 * 10 * CPB + 10);

    // Reset in the middle of data bit 3 with bytes queued.
    for (int i = 0; i < 4; i++) push(8'($urandom));
    idle(15);
    cycle(1'b0, 1'b0, 1'b0, 4'h4, 32'd0);
    address = 4'h4;
    read    = 1'b1;
    #1;
    check32("midframe_reset_status", data_out, 32'h0000_0002);
    idle(60);

    // Overflow clear and the unused register offsets.
    for (int i = 0; i < 10; i++) push(8'($urandom));
    cycle(1'b1, 1'b1, 1'b0, 4'h4 | 4'($urandom_range(0, 3)), $urandom);
    cycle(1'b1, 1'b0, 1'b1, 4'h0 | 4'($urandom_range(0, 3)), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 4'h8 | 4'($urandom_range(0, 3)), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 4'hC | 4'($urandom_range(0, 3)), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 4'hC, $urandom);
    cycle(1'b1, 1'b1, 1'b0, 4'h8, $urandom);
    idle(5);
    idle(9 * 10 * CPB);

    // Random bus traffic, including pushes that coincide with a pop while full.
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      cycle(1'b1, 1'b1, 1'b0, 4'($urandom_range(0, 3)), $urandom);
      else if (r < 49) cycle(1'b1, 1'b1, 1'b0, 4'h4 | 4'($urandom_range(0, 3)), $urandom);
      else if (r < 53) cycle(1'b1, 1'b1, 1'b0, 4'h8 | 4'($urandom_range(0, 7)), $urandom);
      else             cycle(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)), 32'd0);
    end
    idle(9 * 10 * CPB + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
